game_round_ctrl: RTL and testbench

- Round sequencer for the switch-driven memory game.
- Loads the LFSR seed, fills the register file with random symbols, and plays back a growing prefix on the seven-segment path.
- Collects user guesses, scores rounds, and declares win or lose.
- Sits between the switch inputs and the LFSR / register file / display datapath, under the top-level game-state FSM.

---
 rtl/game_round_ctrl_pkg.sv | 29 ++
 rtl/game_round_ctrl_if.sv | 48 ++++
 rtl/game_round_ctrl_hold_timer.sv | 32 +++
 rtl/game_round_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_game_round_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/game_round_ctrl_pkg.sv
// Shared types and defaults for the memory-game round sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_round_ctrl_pkg;

    // Round sequencer states, in the order a normal game walks through them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED  = 3'd1,
        FILL  = 3'd2,
        SHOW  = 3'd3,
        GAP   = 3'd4,
        GUESS = 3'd5,
        WIN   = 3'd6,
        LOSE  = 3'd7
    } state_t;

    localparam int         GAME_DEPTH        = 8;
    localparam int         GAME_DATA_W       = 3;
    localparam int         GAME_HOLD_CYCLES  = 10_000_000;
    localparam logic [7:0] GAME_SEED_DEFAULT = 8'hA5;

    // Counter width for a 0..n-1 count; never narrower than one bit so
    // that n == 1 still yields a legal vector.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Bundle between the round sequencer and its switches / LFSR / register file / display.
// Latency: n/a (wires only); rf_rdata_i must be combinational for rf_addr_o.
// Backpressure: none; ctrl modport drives the datapath, dp modport is the datapath side.
//   user inputs : start_i, submit_i, guess_i
//   LFSR        : rnd_i, seed_load_o, seed_o, lfsr_step_o
//   reg file    : rf_we_o, rf_addr_o, rf_wdata_o, rf_rdata_i
//   display     : disp_val_o, disp_valid_o, score_o, win_o, lose_o
interface game_round_ctrl_if
    import game_round_ctrl_pkg::*;
#(
    parameter int DEPTH  = GAME_DEPTH,
    parameter int DATA_W = GAME_DATA_W
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(DEPTH + 1);

    logic              start_i;
    logic              submit_i;
    logic [DATA_W-1:0] guess_i;
    logic [DATA_W-1:0] rnd_i;
    logic              seed_load_o;
    logic [7:0]        seed_o;
    logic              lfsr_step_o;
    logic              rf_we_o;
    logic [AW-1:0]     rf_addr_o;
    logic [DATA_W-1:0] rf_wdata_o;
    logic [DATA_W-1:0] rf_rdata_i;
    logic [DATA_W-1:0] disp_val_o;
    logic              disp_valid_o;
    logic [SW-1:0]     score_o;
    logic              win_o;
    logic              lose_o;

    modport ctrl (
        input  start_i, submit_i, guess_i, rnd_i, rf_rdata_i,
        output seed_load_o, seed_o, lfsr_step_o,
        output rf_we_o, rf_addr_o, rf_wdata_o,
        output disp_val_o, disp_valid_o, score_o, win_o, lose_o
    );

    modport dp (
        output start_i, submit_i, guess_i, rnd_i, rf_rdata_i,
        input  seed_load_o, seed_o, lfsr_step_o,
        input  rf_we_o, rf_addr_o, rf_wdata_o,
        input  disp_val_o, disp_valid_o, score_o, win_o, lose_o
    );

endinterface

// File: rtl/game_round_ctrl_hold_timer.sv
// Dwell timer for the symbol show / blank gap phases; counts 0..HOLD_CYCLES-1.
// Latency: done is combinational, high in the final enabled cycle of each period.
// Backpressure: none; clr wins over en and restarts the period from 0.
//   ports: clk, rst_n (sync, active-low), clr, en -> done
module hold_timer
    import game_round_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES = GAME_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam int CW = cnt_w(HOLD_CYCLES);

    logic [CW-1:0] cnt_q;

    assign done = en && (cnt_q == CW'(HOLD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || done) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the memory game: seed, fill, play back, collect guesses, score.
// Latency: one clk from a switch edge to the state reaction; show/gap last HOLD_CYCLES each.
// Backpressure: none; only rising edges of start/submit act, submit is dropped when start fires.
//   ports: clk, rst_n (sync, active-low), bus (game_round_ctrl_if.ctrl)
//   ENTROPY_SEED_EN: when defined, seed_o is a free-running counter captured on the
//   new-game start edge; otherwise seed_o is the constant SEED_DEFAULT.
module game_round_ctrl
    import game_round_ctrl_pkg::*;
#(
    parameter int         DEPTH        = GAME_DEPTH,
    parameter int         DATA_W       = GAME_DATA_W,
    parameter int         HOLD_CYCLES  = GAME_HOLD_CYCLES,
    parameter logic [7:0] SEED_DEFAULT = GAME_SEED_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    game_round_ctrl_if.ctrl bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(DEPTH + 1);

    state_t        state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [SW-1:0] len_q, len_d;
    logic [SW-1:0] score_q, score_d;
    logic          start_q, submit_q;
    logic          start_edge, submit_edge;
    logic          timer_en, timer_clr, timer_done;
    logic          round_last, guess_ok, fill_last;

    // ------------------------------------------------------------------
    // State and round context
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            idx_q    <= '0;
            len_q    <= SW'(1);
            score_q  <= '0;
            start_q  <= 1'b0;
            submit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            score_q  <= score_d;
            start_q  <= bus.start_i;
            submit_q <= bus.submit_i;
        end
    end

    assign start_edge  = bus.start_i  & ~start_q;
    assign submit_edge = bus.submit_i & ~submit_q;

    // idx+1 == len avoids the len-1 underflow and needs no extra width.
    assign round_last = (SW'(idx_q) + SW'(1)) == len_q;
    assign guess_ok   = bus.guess_i == bus.rf_rdata_i;
    assign fill_last  = k_q == AW'(DEPTH - 1);

    // The timer restarts on every state change, so a SHOW->GAP->SHOW walk
    // always sees a fresh full-length period in each phase.
    assign timer_en  = (state_q == SHOW) || (state_q == GAP);
    assign timer_clr = state_d != state_q;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .done  (timer_done)
    );

    // ------------------------------------------------------------------
    // Next state and round bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        idx_d   = idx_q;
        len_d   = len_q;
        score_d = score_q;

        unique case (state_q)
            IDLE: begin
                if (start_edge) state_d = SEED;
            end
            SEED: begin
                state_d = start_edge ? IDLE : FILL;
            end
            FILL: begin
                if (start_edge) begin
                    state_d = IDLE;
                end else if (fill_last) begin
                    state_d = SHOW;
                    k_d     = '0;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            SHOW: begin
                if (start_edge)      state_d = IDLE;
                else if (timer_done) state_d = GAP;
            end
            GAP: begin
                if (start_edge) begin
                    state_d = IDLE;
                end else if (timer_done) begin
                    if (!round_last) begin
                        idx_d   = idx_q + AW'(1);
                        state_d = SHOW;
                    end else begin
                        idx_d   = '0;
                        state_d = GUESS;
                    end
                end
            end
            GUESS: begin
                // start is checked first so a same-cycle submit is dropped
                if (start_edge) begin
                    state_d = IDLE;
                end else if (submit_edge) begin
                    if (!guess_ok) begin
                        state_d = LOSE;
                    end else if (!round_last) begin
                        idx_d = idx_q + AW'(1);
                    end else begin
                        score_d = score_q + SW'(1);
                        if (len_q == SW'(DEPTH)) begin
                            state_d = WIN;
                        end else begin
                            len_d   = len_q + SW'(1);
                            idx_d   = '0;
                            state_d = SHOW;
                        end
                    end
                end
            end
            WIN, LOSE: begin
                if (start_edge) state_d = SEED;
            end
            default: state_d = IDLE;
        endcase

        // Both ending a game and starting a new one begin from a clean context.
        if (state_d == IDLE || state_d == SEED) begin
            k_d     = '0;
            idx_d   = '0;
            len_d   = SW'(1);
            score_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath controls, decoded from the registered state only
    // ------------------------------------------------------------------
    always_comb begin
        bus.seed_load_o  = 1'b0;
        bus.lfsr_step_o  = 1'b0;
        bus.rf_we_o      = 1'b0;
        bus.rf_addr_o    = '0;
        bus.rf_wdata_o   = '0;
        bus.disp_val_o   = '0;
        bus.disp_valid_o = 1'b0;
        bus.win_o        = 1'b0;
        bus.lose_o       = 1'b0;

        unique case (state_q)
            SEED: begin
                bus.seed_load_o = 1'b1;
            end
            FILL: begin
                bus.rf_we_o     = 1'b1;
                bus.lfsr_step_o = 1'b1;
                bus.rf_addr_o   = k_q;
                bus.rf_wdata_o  = bus.rnd_i;
            end
            SHOW: begin
                bus.rf_addr_o    = idx_q;
                bus.disp_val_o   = bus.rf_rdata_i;
                bus.disp_valid_o = 1'b1;
            end
            GUESS: begin
                bus.rf_addr_o = idx_q;
            end
            WIN: begin
                bus.win_o        = 1'b1;
                bus.disp_valid_o = 1'b1;
                bus.disp_val_o   = DATA_W'(score_q);
            end
            LOSE: begin
                bus.lose_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.score_o = score_q;

    // ------------------------------------------------------------------
    // Seed source
    // ------------------------------------------------------------------
`ifdef ENTROPY_SEED_EN
    logic [7:0] ent_cnt_q;
    logic [7:0] seed_q;

    // Capturing the counter at the press ties each game to human timing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_cnt_q <= '0;
            seed_q    <= '0;
        end else begin
            ent_cnt_q <= ent_cnt_q + 8'd1;
            if (start_edge && (state_q == IDLE || state_q == WIN || state_q == LOSE)) begin
                seed_q <= ent_cnt_q;
            end
        end
    end

    assign bus.seed_o = seed_q;
`else
    assign bus.seed_o = SEED_DEFAULT;
`endif

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl with DEPTH=4, HOLD_CYCLES=3.
// Latency: n/a.
// Backpressure: n/a.
module tb_game_round_ctrl;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 3;
    localparam int HOLD   = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    game_round_ctrl_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus();

    game_round_ctrl #(
        .DEPTH        (DEPTH),
        .DATA_W       (DATA_W),
        .HOLD_CYCLES  (HOLD),
        .SEED_DEFAULT (8'hA5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register-file stand-in: write on rf_we_o, combinational read.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) if (bus.rf_we_o) mem[bus.rf_addr_o] <= bus.rf_wdata_o;
    assign bus.rf_rdata_i = mem[bus.rf_addr_o];

    int checks = 0;
    int errors = 0;

    // Reference model: the symbols of the current game and rounds completed.
    logic [DATA_W-1:0] exp_sym [DEPTH];
    int                exp_score;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        bus.rnd_i = DATA_W'($urandom);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_seed_load"},  32'(bus.seed_load_o), 0);
        chk({tag, "_lfsr_step"},  32'(bus.lfsr_step_o), 0);
        chk({tag, "_rf_we"},      32'(bus.rf_we_o), 0);
        chk({tag, "_rf_addr"},    32'(bus.rf_addr_o), 0);
        chk({tag, "_rf_wdata"},   32'(bus.rf_wdata_o), 0);
        chk({tag, "_disp_val"},   32'(bus.disp_val_o), 0);
        chk({tag, "_disp_valid"}, 32'(bus.disp_valid_o), 0);
        chk({tag, "_score"},      32'(bus.score_o), 0);
        chk({tag, "_win"},        32'(bus.win_o), 0);
        chk({tag, "_lose"},       32'(bus.lose_o), 0);
        chk({tag, "_seed"},       32'(bus.seed_o), 32'hA5);
    endtask

    task automatic press_start();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    // Submit with a low cycle first so every press is a fresh rising edge.
    task automatic guess(input logic [DATA_W-1:0] g);
        bus.guess_i  = g;
        bus.submit_i = 1'b0;
        tick();
        bus.submit_i = 1'b1;
        tick();
        bus.submit_i = 1'b0;
    endtask

    // Called in the first cycle after a new-game start edge; drives exp_sym
    // as the LFSR output during the fill and leaves the cursor on the first show cycle.
    task automatic expect_seed_fill();
        exp_score = 0;
        chk("seed_load",  32'(bus.seed_load_o), 1);
        chk("seed_we",    32'(bus.rf_we_o), 0);
        chk("seed_score", 32'(bus.score_o), 0);
        chk("seed_win",   32'(bus.win_o), 0);
        chk("seed_lose",  32'(bus.lose_o), 0);
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            bus.rnd_i = exp_sym[k];
            #1;
            chk("fill_we",     32'(bus.rf_we_o), 1);
            chk("fill_addr",   32'(bus.rf_addr_o), k);
            chk("fill_data",   32'(bus.rf_wdata_o), 32'(exp_sym[k]));
            chk("fill_step",   32'(bus.lfsr_step_o), 1);
            chk("fill_seedld", 32'(bus.seed_load_o), 0);
        end
        tick();
        chk("post_fill_we", 32'(bus.rf_we_o), 0);
    endtask

    // Playback of the first len symbols; ends on the first guess cycle.
    task automatic expect_show(input int len);
        for (int i = 0; i < len; i++) begin
            for (int h = 0; h < HOLD; h++) begin
                chk("show_valid", 32'(bus.disp_valid_o), 1);
                chk("show_val",   32'(bus.disp_val_o), 32'(exp_sym[i]));
                tick();
            end
            for (int h = 0; h < HOLD; h++) begin
                chk("gap_valid", 32'(bus.disp_valid_o), 0);
                tick();
            end
        end
        chk("guess_blank", 32'(bus.disp_valid_o), 0);
    endtask

    // One round of length len; guess wrong_at (if >= 0) is corrupted by mask.
    task automatic play_round(input int len, input int wrong_at,
                              input logic [DATA_W-1:0] mask, output bit alive);
        logic [DATA_W-1:0] g;
        alive = 1'b1;
        expect_show(len);
        for (int i = 0; i < len; i++) begin
            g = exp_sym[i];
            if (i == wrong_at) g = g ^ mask;
            guess(g);
            if (i == wrong_at) begin
                chk("lose_flag",  32'(bus.lose_o), 1);
                chk("lose_win",   32'(bus.win_o), 0);
                chk("lose_blank", 32'(bus.disp_valid_o), 0);
                chk("lose_score", 32'(bus.score_o), exp_score);
                alive = 1'b0;
                return;
            end
            if (i < len - 1) begin
                chk("mid_lose",  32'(bus.lose_o), 0);
                chk("mid_score", 32'(bus.score_o), exp_score);
            end
        end
        exp_score++;
        chk("round_score", 32'(bus.score_o), exp_score);
        if (len == DEPTH) begin
            chk("win_flag",  32'(bus.win_o), 1);
            chk("win_valid", 32'(bus.disp_valid_o), 1);
            chk("win_val",   32'(bus.disp_val_o), exp_score % (1 << DATA_W));
            alive = 1'b0;
        end else begin
            chk("next_show", 32'(bus.disp_valid_o), 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit alive;
        int wrong_at;

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        rst_n        = 1'b0;
        bus.start_i  = 1'b0;
        bus.submit_i = 1'b0;
        bus.guess_i  = '0;
        bus.rnd_i    = '0;
        exp_score    = 0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        check_idle("reset");

        // Directed game: 5,2,7,1; round 1 correct, round 2 wrong on the second symbol (3).
        exp_sym[0] = 3'd5; exp_sym[1] = 3'd2; exp_sym[2] = 3'd7; exp_sym[3] = 3'd1;
        press_start();
        expect_seed_fill();
        play_round(1, -1, 3'd0, alive);
        play_round(2, 1, 3'd1, alive);
        guess(3'd2);
        chk("lose_ignores_submit", 32'(bus.lose_o), 1);
        chk("lose_keeps_score",    32'(bus.score_o), 1);

        // Full game won.
        for (int i = 0; i < DEPTH; i++) exp_sym[i] = DATA_W'($urandom);
        press_start();
        expect_seed_fill();
        for (int len = 1; len <= DEPTH; len++) play_round(len, -1, 3'd0, alive);
        tick();
        chk("win_holds", 32'(bus.win_o), 1);

        // New game from WIN, then abort during SHOW.
        for (int i = 0; i < DEPTH; i++) exp_sym[i] = DATA_W'($urandom);
        press_start();
        expect_seed_fill();
        press_start();
        check_idle("abort_show");
        guess(3'd0);
        check_idle("idle_submit");

        // Start and submit in the same guess cycle: start wins.
        press_start();
        expect_seed_fill();
        expect_show(1);
        bus.guess_i  = exp_sym[0];
        bus.start_i  = 1'b1;
        bus.submit_i = 1'b1;
        tick();
        bus.start_i  = 1'b0;
        bus.submit_i = 1'b0;
        check_idle("start_submit");
        for (int h = 0; h < 2 * HOLD; h++) begin
            tick();
            chk("stay_idle_valid", 32'(bus.disp_valid_o), 0);
            chk("stay_idle_score", 32'(bus.score_o), 0);
        end

        // Reset in the middle of the fill.
        press_start();
        chk("rst_fill_seed", 32'(bus.seed_load_o), 1);
        tick(); tick();
        chk("rst_fill_we", 32'(bus.rf_we_o), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle("reset_mid_fill");
        for (int h = 0; h < 8; h++) begin
            tick();
            chk("no_we_after_rst", 32'(bus.rf_we_o), 0);
        end

        // Randomized games: random symbols, occasional wrong guess.
        for (int gm = 0; gm < 8; gm++) begin
            for (int i = 0; i < DEPTH; i++) exp_sym[i] = DATA_W'($urandom);
            press_start();
            expect_seed_fill();
            for (int len = 1; len <= DEPTH; len++) begin
                wrong_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
                play_round(len, wrong_at, DATA_W'($urandom_range(1, 7)), alive);
                if (!alive) break;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
